// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
//   req_valid/req_ready : request handshake (initiator -> responder)
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata           : store data
//   rsp_valid/rsp_ready : response handshake (responder -> initiator)
//   rsp_rdata           : load data, 0 for stores and errors
//   rsp_err             : request was misaligned or out of range
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, then a response is
// held in RESP until the initiator takes it.
//   clk : sole clock
//   rst : synchronous active-high reset; clears state, counter and all memory words
//   bus : dmem_responder_if slave modport (request and response handshakes)
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;

  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  // With zero wait states RESP is entered on the accept edge itself, before the
  // capture registers hold the request, so the store path looks at the live bus
  // in IDLE and at the captured copy otherwise.
  logic          cur_write;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic          mem_we;

  logic          rsp_err_int;
  logic [AW-1:0] rsp_idx;
  logic          in_resp;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // Store commit on the edge that enters RESP
  always_comb begin
    if (state_q == StIdle) begin
      cur_write = bus.req_write;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_err = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= DEPTH);
    cur_idx = cur_addr[AW+1:2];
    mem_we  = (state_d == StResp) && (state_q != StResp) && cur_write && !cur_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 32'd0;
      end
    end else if (mem_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  // Response outputs; memory is not written while in RESP, so the load data is stable
  always_comb begin
    in_resp     = (state_q == StResp);
    rsp_err_int = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH);
    rsp_idx     = addr_q[AW+1:2];
    bus.req_ready = (state_q == StIdle) && !rst;
    bus.rsp_valid = in_resp;
    bus.rsp_err   = in_resp && rsp_err_int;
    bus.rsp_rdata = (in_resp && !rsp_err_int && !write_q) ? mem[rsp_idx] : 32'd0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, hand-written reset and
// zero-wait sequences, then random traffic against an array-based memory model.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAIT  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'd0;
  endtask

  // One full transaction; the expected response comes from the memory model.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] got_rdata, output bit got_err);
    logic [31:0] idx;
    logic [5:0]  widx;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          lat;
    idx       = addr >> 2;
    widx      = idx[5:0];
    exp_err   = (addr % 4 != 0) || (idx >= DEPTH);
    exp_rdata = (!exp_err && !wr) ? model_mem[widx] : 32'd0;
    lat = 0;
    while (!bus.req_ready && lat < 20) begin
      tick;
      lat++;
    end
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick;
    // Garbage on the request lines while busy must be ignored
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      chk("busy_rdata_zero", bus.rsp_rdata, 32'd0);
      chk("busy_err_zero", {31'd0, bus.rsp_err}, 32'd0);
      chk("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
      tick;
      lat++;
    end
    chk("latency", lat, WAIT + 1);
    got_rdata = bus.rsp_rdata;
    got_err   = bus.rsp_err;
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
    if (wr && !exp_err) model_mem[widx] = wdata;
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_rdata", bus.rsp_rdata, exp_rdata);
      chk("hold_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("post_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got_rdata;
    bit          got_err;
    int          acc;
    bit          prev_acc;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h13,  32'h0,        0, 32'h0,        1'b1};
    vecs[3]  = '{1'b0, 32'h100, 32'h0,        0, 32'h0,        1'b1};
    vecs[4]  = '{1'b1, 32'h100, 32'hA5A5A5A5, 1, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h0,   32'h0,        0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'hFC,  32'h13572468, 2, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'hFC,  32'h0,        5, 32'h13572468, 1'b0};
    vecs[8]  = '{1'b0, 32'h10,  32'h0,        1, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b1, 32'h10,  32'h0BADF00D, 0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h10,  32'h0,        3, 32'h0BADF00D, 1'b0};

    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = 32'd0;
    bus0.req_wdata = 32'd0;
    bus0.rsp_ready = 1'b1;
    model_clear();

    tick;
    tick;
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("after_reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("after_reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold, got_rdata, got_err);
      chk($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, got_err}, {31'd0, vecs[i].exp_err});
    end

    // The out-of-range store must not have touched any word
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_req(1'b0, 32'(i * 4), 32'd0, 0, got_rdata, got_err);
    end

    // Reset in the middle of a store's wait states
    while (!bus.req_ready) tick;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h4;
    bus.req_wdata = 32'h12345678;
    tick;
    bus.req_valid = 1'b0;
    tick;
    chk("midwait_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_high_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    model_clear();
    do_req(1'b0, 32'h4, 32'd0, 0, got_rdata, got_err);
    chk("discarded_store", got_rdata, 32'h00000000);
    do_req(1'b0, 32'h10, 32'd0, 0, got_rdata, got_err);
    chk("load_after_reset", got_rdata, 32'h00000000);

    // Zero wait states: continuous requests, response always taken
    bus0.req_valid = 1'b1;
    acc      = 0;
    prev_acc = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk("w0_rsp_valid", {31'd0, bus0.rsp_valid}, {31'd0, prev_acc});
      chk("w0_rsp_rdata", bus0.rsp_rdata, 32'd0);
      prev_acc = bus0.req_ready;
      if (bus0.req_ready) acc++;
      tick;
    end
    bus0.req_valid = 1'b0;
    chk("w0_accept_count", acc, 10);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      int          sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = $urandom_range(0, 63) * 4;
      else if (sel == 7) a = $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
      else if (sel == 8) a = $urandom_range(64, 1000) * 4;
      else               a = $urandom | 32'h0001_0000;
      do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), got_rdata, got_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
